// File: rtl/conv_pkg.sv
// Shared constants, tap bundle and scheduler state type for the conv layer-1/layer-2 pipeline.
package conv_pkg;

  localparam int L1_OUT_W   = 26;
  localparam int L1_OUT_H   = 26;
  localparam int KSIZE      = 3;
  localparam int L1_OUT_NUM = L1_OUT_W * L1_OUT_H;
  localparam int L1_DW      = 8;

  typedef struct packed {
    logic [L1_DW-1:0] data;
    logic [3:0]       idx;
    logic             win_last;
    logic             frame_last;
  } tap_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/win_addr_gen.sv
// Window/tap counters for the 3x3 raster walk and the matching buffer read address.
module win_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = L1_OUT_W,
  parameter int IMG_H = L1_OUT_H,
  parameter int K     = KSIZE,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [AW-1:0] addr,
  output logic [3:0]    idx,
  output logic          win_last,
  output logic          frame_last
);

  localparam int RW = (IMG_H - K + 1 > 1) ? $clog2(IMG_H - K + 1) : 1;
  localparam int CW = (IMG_W - K + 1 > 1) ? $clog2(IMG_W - K + 1) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  localparam logic [RW-1:0] WROW_LAST = RW'(IMG_H - K);
  localparam logic [CW-1:0] WCOL_LAST = CW'(IMG_W - K);
  localparam logic [KW-1:0] K_LAST    = KW'(K - 1);

  logic [RW-1:0] wrow_q, wrow_d;
  logic [CW-1:0] wcol_q, wcol_d;
  logic [KW-1:0] ky_q, ky_d;
  logic [KW-1:0] kx_q, kx_d;

  // kx fastest, then ky, then window column, then window row
  always_comb begin
    wrow_d = wrow_q;
    wcol_d = wcol_q;
    ky_d   = ky_q;
    kx_d   = kx_q;
    if (clr) begin
      wrow_d = '0;
      wcol_d = '0;
      ky_d   = '0;
      kx_d   = '0;
    end else if (adv) begin
      if (kx_q != K_LAST) begin
        kx_d = kx_q + KW'(1);
      end else begin
        kx_d = '0;
        if (ky_q != K_LAST) begin
          ky_d = ky_q + KW'(1);
        end else begin
          ky_d = '0;
          if (wcol_q != WCOL_LAST) begin
            wcol_d = wcol_q + CW'(1);
          end else begin
            wcol_d = '0;
            wrow_d = (wrow_q != WROW_LAST) ? wrow_q + RW'(1) : '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrow_q <= '0;
      wcol_q <= '0;
      ky_q   <= '0;
      kx_q   <= '0;
    end else begin
      wrow_q <= wrow_d;
      wcol_q <= wcol_d;
      ky_q   <= ky_d;
      kx_q   <= kx_d;
    end
  end

  logic [AW-1:0] row_sum, col_sum;

  // AW bits hold the full map (max 675) so no wrap occurs
  assign row_sum    = AW'(wrow_q) + AW'(ky_q);
  assign col_sum    = AW'(wcol_q) + AW'(kx_q);
  assign addr       = row_sum * AW'(IMG_W) + col_sum;
  assign idx        = 4'(ky_q) * 4'(K) + 4'(kx_q);
  assign win_last   = (ky_q == K_LAST) && (kx_q == K_LAST);
  assign frame_last = win_last && (wrow_q == WROW_LAST) && (wcol_q == WCOL_LAST);

endmodule

// File: rtl/layer2_window_sched.sv
// Layer-1 buffer read scheduler: walks all 3x3 windows and streams tagged taps to layer 2.
// Optional stall counter output enabled by defining WIN_SCHED_STALL_CNT_EN.
module layer2_window_sched
  import conv_pkg::*;
#(
  parameter int IMG_W = L1_OUT_W,
  parameter int IMG_H = L1_OUT_H,
  parameter int K     = KSIZE,
  parameter int AW    = 10,
  parameter int DW    = L1_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_complete,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          tap_valid,
  input  logic          tap_ready,
  output logic [DW-1:0] tap_data,
  output logic [3:0]    tap_idx,
  output logic          win_last,
  output logic          frame_last,
  output logic          busy,
  output logic          done
`ifdef WIN_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cycles
`endif
);

  sched_state_e state_q, state_d;
  logic         armed_q, armed_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [1:0]   occ_q, occ_d;
  logic         inflight_q, inflight_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [5:0]   pend_q, pend_d;
  tap_t         fifo_q [2];
  tap_t         fifo_d [2];

  logic [AW-1:0] gen_addr;
  logic [3:0]    gen_idx;
  logic          gen_win_last;
  logic          gen_frame_last;

  logic start, pop, push, issue_ok;
  tap_t head;

  assign start     = (state_q == ST_IDLE) && wr_complete && armed_q;
  assign tap_valid = (occ_q != 2'd0);
  assign pop       = tap_valid && tap_ready;
  assign push      = inflight_q;
  // A slot freed by this cycle's pop can be refilled by this cycle's read
  assign issue_ok  = (3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));
  assign rd_en     = (state_q == ST_RUN) && issue_ok;
  assign rd_addr   = rd_en ? gen_addr : '0;

  win_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .AW    (AW)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clr        (start),
    .adv        (rd_en),
    .addr       (gen_addr),
    .idx        (gen_idx),
    .win_last   (gen_win_last),
    .frame_last (gen_frame_last)
  );

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    done_d     = 1'b0;
    occ_d      = occ_q;
    inflight_d = rd_en;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pend_d     = pend_q;
    fifo_d     = fifo_q;

    if (!wr_complete) armed_d = 1'b1;

    // Tags travel alongside the read so they meet the data one cycle later
    if (rd_en) pend_d = {gen_idx, gen_win_last, gen_frame_last};

    if (push) begin
      fifo_d[wr_ptr_q] = tap_t'{data: rd_data, idx: pend_q[5:2],
                                win_last: pend_q[1], frame_last: pend_q[0]};
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          armed_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (rd_en && gen_frame_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((occ_d == 2'd0) && !inflight_d) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      pend_q     <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pend_q     <= pend_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
    end
  end

  assign head       = fifo_q[rd_ptr_q];
  assign tap_data   = head.data;
  assign tap_idx    = head.idx;
  assign win_last   = head.win_last;
  assign frame_last = head.frame_last;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef WIN_SCHED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start) begin
      stall_d = '0;
    end else if ((state_q != ST_IDLE) && tap_valid && !tap_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_layer2_window_sched.sv
// Directed bench for layer2_window_sched: full frames with steady and random tap_ready,
// re-arm behaviour, mid-frame reset and withdrawn write-complete flag.
module tb_layer2_window_sched;

  localparam int NTAP   = 5184;
  localparam int BUDGET = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_complete = 1'b0;
  logic       tap_ready = 1'b0;
  logic [7:0] rd_data = 8'd0;

  logic       rd_en;
  logic [9:0] rd_addr;
  logic       tap_valid;
  logic [7:0] tap_data;
  logic [3:0] tap_idx;
  logic       win_last;
  logic       frame_last;
  logic       busy;
  logic       done;
`ifdef WIN_SCHED_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  logic [7:0] mem [0:1023];

  layer2_window_sched dut (
    .clk         (clk),
    .rst         (rst),
    .wr_complete (wr_complete),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .tap_valid   (tap_valid),
    .tap_ready   (tap_ready),
    .tap_data    (tap_data),
    .tap_idx     (tap_idx),
    .win_last    (win_last),
    .frame_last  (frame_last),
    .busy        (busy),
    .done        (done)
`ifdef WIN_SCHED_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(input int n);
    int w, t;
    w = n / 9;
    t = n % 9;
    return ((w / 24) + (t / 3)) * 26 + (w % 24) + (t % 3);
  endfunction

  int r_taps, r_iss, r_addr_err, r_data_err, r_idx_err, r_wl_err, r_fl_err;
  int r_stab_err, r_lim_err, r_done, r_stall, r_first_rd, r_first_tv, r_done_cyc, r_busy_err;
  int first_addr [12];

  task automatic run_frame(input bit rnd, input int drop_at, input int abort_at, output bit aborted);
    int k, pending, post, ea;
    bit prev_stall, dropped, fin, pop;
    logic [13:0] prev_bus;
    r_taps = 0; r_iss = 0; r_addr_err = 0; r_data_err = 0; r_idx_err = 0;
    r_wl_err = 0; r_fl_err = 0; r_stab_err = 0; r_lim_err = 0; r_done = 0;
    r_stall = 0; r_first_rd = -1; r_first_tv = -1; r_done_cyc = -1; r_busy_err = 0;
    k = 0; pending = 0; post = 0; prev_stall = 0; dropped = 0; fin = 0; aborted = 0;
    prev_bus = '0;
    wr_complete = 1'b1;
    tap_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (k < BUDGET && !(fin && post >= 6)) begin
      @(negedge clk);
      pop = tap_valid && tap_ready;
      if (rd_en) begin
        if (r_iss < 12) first_addr[r_iss] = int'(rd_addr);
        if (int'(rd_addr) != exp_addr(r_iss)) r_addr_err++;
        if (r_first_rd < 0) r_first_rd = k;
        if (pending - (pop ? 1 : 0) >= 2) r_lim_err++;
        r_iss++;
      end
      if (prev_stall && (!tap_valid || {tap_data, tap_idx, win_last, frame_last} != prev_bus))
        r_stab_err++;
      if (tap_valid && r_first_tv < 0) r_first_tv = k;
      if (tap_valid && !tap_ready) r_stall++;
      if (pop) begin
        ea = exp_addr(r_taps);
        if (int'(tap_data) != (ea & 255)) r_data_err++;
        if (int'(tap_idx) != r_taps % 9) r_idx_err++;
        if (win_last != (r_taps % 9 == 8)) r_wl_err++;
        if (frame_last != (r_taps == NTAP - 1)) r_fl_err++;
        r_taps++;
      end
      if (k == 1 && !busy) r_busy_err++;
      if (done) begin
        r_done++;
        if (!fin) r_done_cyc = k;
        if (busy) r_busy_err++;
        fin = 1;
      end
      if (fin) post++;
      pending = pending + (rd_en ? 1 : 0) - (pop ? 1 : 0);
      prev_stall = tap_valid && !tap_ready;
      prev_bus = {tap_data, tap_idx, win_last, frame_last};
      k++;
      if (abort_at >= 0 && r_taps == abort_at) begin
        rst = 1'b0;
        #1;
        check_val("rst_midframe_outputs",
                  32'({rd_en, rd_addr, tap_valid, tap_data, tap_idx, win_last, frame_last, busy, done}),
                  32'd0);
        aborted = 1;
        return;
      end
      @(posedge clk);
      #1;
      tap_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (drop_at >= 0 && r_taps >= drop_at && !dropped) begin
        wr_complete = 1'b0;
        dropped = 1;
      end
    end
    check_val("frame_within_budget", 32'(fin), 32'd1);
  endtask

  task automatic check_frame(input string name, input bit timing);
    $display("frame %s: taps=%0d issues=%0d first_rd=%0d first_tv=%0d done_at=%0d stalls=%0d",
             name, r_taps, r_iss, r_first_rd, r_first_tv, r_done_cyc, r_stall);
    check_val({name, "_taps"}, r_taps, NTAP);
    check_val({name, "_issues"}, r_iss, NTAP);
    check_val({name, "_addr_err"}, r_addr_err, 0);
    check_val({name, "_data_err"}, r_data_err, 0);
    check_val({name, "_idx_err"}, r_idx_err, 0);
    check_val({name, "_win_last_err"}, r_wl_err, 0);
    check_val({name, "_frame_last_err"}, r_fl_err, 0);
    check_val({name, "_stall_stability_err"}, r_stab_err, 0);
    check_val({name, "_issue_limit_err"}, r_lim_err, 0);
    check_val({name, "_done_pulses"}, r_done, 1);
    check_val({name, "_busy_err"}, r_busy_err, 0);
    check_val({name, "_busy_after"}, 32'(busy), 32'd0);
    if (timing) begin
      check_val({name, "_first_rd_cycle"}, r_first_rd, 1);
      check_val({name, "_first_tap_cycle"}, r_first_tv, 3);
      check_val({name, "_done_cycle"}, r_done_cyc, NTAP + 3);
    end
`ifdef WIN_SCHED_STALL_CNT_EN
    check_val({name, "_stall_cycles"}, 32'(stall_cycles), r_stall);
`endif
  endtask

  initial begin
    int exp_first [12];
    int cnt;
    bit ab;
    exp_first = '{0, 1, 2, 26, 27, 28, 52, 53, 54, 1, 2, 3};
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_outputs",
              32'({rd_en, rd_addr, tap_valid, tap_data, tap_idx, win_last, frame_last, busy, done}),
              32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    run_frame(1'b0, -1, -1, ab);
    check_frame("f1_ready_high", 1'b1);
    for (int i = 0; i < 12; i++)
      check_val($sformatf("f1_addr%0d", i), first_addr[i], exp_first[i]);

    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (rd_en || busy || done) cnt++;
    end
    $display("rearm hold: active cycles with wr_complete held=%0d", cnt);
    check_val("no_second_frame", cnt, 0);

    @(posedge clk);
    #1 wr_complete = 1'b0;
    @(posedge clk);
    #1;
    run_frame(1'b1, -1, -1, ab);
    check_frame("f2_random_ready", 1'b0);

    wr_complete = 1'b0;
    @(posedge clk);
    #1;
    run_frame(1'b0, -1, 1000, ab);
    $display("abort frame: reset applied at tap %0d", r_taps);
    check_val("abort_reached", 32'(ab), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    run_frame(1'b0, -1, -1, ab);
    check_frame("f4_after_reset", 1'b1);
    check_val("f4_first_addr", first_addr[0], 0);

    wr_complete = 1'b0;
    @(posedge clk);
    #1;
    run_frame(1'b1, 2000, -1, ab);
    check_frame("f5_withdrawn", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/layer2_window_sched.md
# layer2_window_sched

Read scheduler for the layer-1 feature-map buffer (26×26 × 8-bit, written by conv layer 1). It waits for the buffer's write-complete flag, then walks every 3×3 window of the map in raster order and issues `rd_en`/`rd_addr` to the buffer RAM. Returned bytes go out as a tagged tap stream (valid/ready) to the layer-2 convolution unit. The block owns the read port of the layer-1 buffer; no other requester drives it while a frame is in progress.

## Interface
- `IMG_W`, 26, feature-map width
- `IMG_H`, 26, feature-map height
- `K`, 3, kernel side
- `AW`, 10, RAM address width
- `DW`, 8, data width
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr_complete` in 1: layer-1 buffer write-complete flag (sticky level).
- `rd_en` out 1: RAM read strobe.
- `rd_addr` out AW: RAM read address.
- `rd_data` in DW: RAM data, valid exactly 1 cycle after `rd_en`.
- `tap_valid` out 1: a tap is presented.
- `tap_ready` in 1: consumer accepts the tap.
- `tap_data` out DW: pixel value.
- `tap_idx` out 4: tap index within window, 0..8, computed as ky*K+kx.
- `win_last` out 1: high on tap 8.
- `frame_last` out 1: high on the final tap of the final window.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse after the final tap is accepted.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
- **Reset:** state IDLE. All outputs 0. Counters 0. `armed` = 1.
- **IDLE → RUN:** when `wr_complete` && `armed`. The same edge clears `armed`. `armed` is set again whenever `wr_complete` is sampled low, so each frame is scheduled exactly once.
- **Counters:** `wrow`/`wcol` run 0..IMG_H-K and 0..IMG_W-K. `ky`/`kx` run 0..K-1.
- **Visit order:** windows in row-major order, taps within a window with ky major.
- **Address:** `rd_addr` = (wrow+ky)*IMG_W + (wcol+kx). The computation is done at AW bits. The maximum value is 675 and must not wrap.
- **Output buffer:** a 2-entry FIFO holds {data, idx, win_last, frame_last}. Each entry is written from `rd_data` in the cycle after its `rd_en`.
- **Issue rule:** `rd_en` is asserted when occ + inflight − pop < 2, where pop = `tap_valid` && `tap_ready`. Overflow is impossible. Ready held high gives 1 tap/cycle.
- **RUN → DRAIN:** in the cycle the last address (wrow=IMG_H-K, wcol=IMG_W-K, ky=kx=2) is issued.
- **DRAIN → IDLE:** when the FIFO is empty and nothing is in flight, i.e. the final tap has been accepted. `done` pulses that same cycle and `busy` falls.
- **Totals:** 576 windows, 5184 taps per frame.
- **Withdrawn flag:** if `wr_complete` falls mid-frame, the frame still completes.
- **Reset mid-frame:** everything returns to reset values immediately, in-flight data is discarded, and `armed` = 1.

## Timing
- First `rd_en` is in the cycle after IDLE→RUN.
- `tap_valid` first rises 2 cycles after that first `rd_en` (RAM 1 cycle plus FIFO register).
- With `tap_ready` held high: steady-state 1 tap/cycle. `done` comes 5184 + 3 cycles after the IDLE→RUN cycle.
- **Stall stability:** `tap_data`, `tap_idx`, `win_last` and `frame_last` are stable while `tap_valid` && !`tap_ready`.
- **No withdrawal:** `tap_valid` never drops without acceptance.
- `busy` = (state != IDLE), registered.

## Configuration
- `WIN_SCHED_STALL_CNT_EN` defined:
  - Adds output `stall_cycles` [15:0].
  - It counts cycles with `tap_valid` && !`tap_ready` during a frame and saturates at 0xFFFF.
  - It clears on the IDLE→RUN transition and holds its value after `done`.
- Undefined: no port and no counter logic.

## Structure
- **Shared package** `conv_pkg`:
  - Constants `L1_OUT_W`=26, `L1_OUT_H`=26, `KSIZE`=3, `L1_OUT_NUM`=676.
  - Tap bundle typedef {data, idx, win_last, frame_last}.
  - FSM state enum.
- **Sub-module** `win_addr_gen`: the wrow/wcol/ky/kx counters and address computation, advanced by an `adv` input.
- **Top-level:** FSM, credit/issue logic, 2-entry FIFO.

## Test plan
- Reset, then `wr_complete`=1 with `tap_ready`=1 held.
  - `rd_addr` sequence begins 0,1,2,26,27,28,52,53,54,1,2,3.
  - `tap_idx` cycles 0..8 with `win_last` on 8.
  - 5184 taps, `frame_last` on the last tap (address 675), one `done` pulse.
- Buffer preloaded with mem[a]=a[7:0]: every tap's data equals the low byte of its computed address.
- Random `tap_ready` (50%):
  - no tap lost or duplicated;
  - outputs stable during stalls;
  - `rd_en` never issued with FIFO plus in-flight count at 2;
  - with `WIN_SCHED_STALL_CNT_EN`, `stall_cycles` equals the bench's stall count.
- `wr_complete` held high after `done`: no second frame. Drop it for 1 cycle and raise it again: a second identical frame runs.
- Assert `rst`=0 at tap 1000: all outputs 0 immediately. After release with `wr_complete`=1, a full frame restarts at address 0.
- `wr_complete` dropped mid-frame: the frame still completes with 5184 taps.
